// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb
// Round-robin write arbiter that shares one synchronous FIFO write port
// among N requesters. A requester is granted for a burst of up to MAX_BURST
// words. The grant ends early on its last word or when it withdraws.
// Every release is followed by exactly one IDLE cycle before the next grant.
// fifo_winc is never raised while the FIFO reports full.
//
// Ports
//   i_clk          single clock, all logic on posedge
//   i_rst_n        synchronous active-low reset
//   i_req_valid    [N]        requester i presents a word
//   i_req_last     [N]        requester i's word is its last; releases grant
//   i_req_data     [N*WIDTH]  requester i's data on [i*WIDTH +: WIDTH]
//   o_req_ready    [N]        word from the granted requester accepted now
//   i_fifo_wfull              FIFO full flag
//   o_fifo_winc               FIFO write strobe
//   o_fifo_wdata   [WIDTH]    FIFO write data (0 when idle)
//   o_gnt          [N]        registered one-hot grant, 0 when idle
//   o_busy                    registered, high while a grant is held
module sfifo_wr_arb #(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N-1:0]       i_req_valid,
  input  logic [N-1:0]       i_req_last,
  input  logic [N*WIDTH-1:0] i_req_data,
  output logic [N-1:0]       o_req_ready,
  input  logic               i_fifo_wfull,
  output logic               o_fifo_winc,
  output logic [WIDTH-1:0]   o_fifo_wdata,
  output logic [N-1:0]       o_gnt,
  output logic               o_busy
);

  localparam int IW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_gidx;
  logic [IW-1:0]   r_ptr;
  logic [BW-1:0]   r_bcnt;
  logic [N-1:0]    r_gnt;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_gidx_nxt;
  logic [IW-1:0]   w_ptr_nxt;
  logic [BW-1:0]   w_bcnt_nxt;
  logic [N-1:0]    w_gnt_nxt;
  logic            w_busy_nxt;

  logic            w_found;
  logic [IW-1:0]   w_sel_idx;
  logic [N-1:0]    w_sel_onehot;
  logic            w_cur_valid;
  logic            w_cur_last;
  logic            w_accept;
  logic            w_release;

  // Round-robin search: first valid requester at or after r_ptr, wrapping
  // explicitly so non-power-of-two N never selects a missing requester.
  always_comb begin
    int idx;
    logic [IW-1:0] w_idx;
    idx          = 0;
    w_idx        = '0;
    w_found      = 1'b0;
    w_sel_idx    = '0;
    w_sel_onehot = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      w_idx = idx[IW-1:0];
      if (!w_found && i_req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_sel_idx = w_idx;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (w_found && (w_sel_idx == IW'(k))) w_sel_onehot[k] = 1'b1;
    end
  end

  // Accept is purely combinational so a same-cycle drop of wfull is used
  // immediately. A withdrawn requester releases even when the FIFO is full.
  always_comb begin
    w_cur_valid  = i_req_valid[r_gidx];
    w_cur_last   = i_req_last[r_gidx];
    w_accept     = (r_state == ST_GRANT) && w_cur_valid && !i_fifo_wfull;
    w_release    = (r_state == ST_GRANT) &&
                   ((w_accept && (w_cur_last || (r_bcnt == BW'(MAX_BURST - 1)))) ||
                    !w_cur_valid);
    o_fifo_winc  = w_accept;
    o_req_ready  = '0;
    o_fifo_wdata = '0;
    for (int k = 0; k < N; k++) begin
      if (r_gidx == IW'(k)) begin
        o_req_ready[k] = w_accept;
        if (r_state == ST_GRANT) o_fifo_wdata = i_req_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state logic. The pointer moves past the released requester so the
  // next arbitration starts with its neighbour.
  always_comb begin
    w_state_nxt = r_state;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_bcnt_nxt  = r_bcnt;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gidx_nxt  = w_sel_idx;
          w_bcnt_nxt  = '0;
          w_gnt_nxt   = w_sel_onehot;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_bcnt_nxt  = '0;
          w_ptr_nxt   = (r_gidx == IW'(N - 1)) ? '0 : r_gidx + IW'(1);
        end else if (w_accept) begin
          w_bcnt_nxt = r_bcnt + BW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_bcnt  <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_gnt  = r_gnt;
  assign o_busy = r_busy;

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb_sfifo_wr_arb
// Directed bench for sfifo_wr_arb. A 16-deep FIFO model sits behind the
// N=4 instance. A second N=3 instance exercises pointer wrap.
module tb_sfifo_wr_arb;

  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]       reqValid;
  logic [N-1:0]       reqLast;
  logic [7:0]         reqData [N];
  logic [N*WIDTH-1:0] reqDataBus;
  logic [N-1:0]       reqReady;
  logic [N-1:0]       gnt;
  logic               winc;
  logic               busy;
  logic               wfull;
  logic [7:0]         wdata;

  logic [2:0]  vb3;
  logic [2:0]  last3;
  logic [23:0] data3;
  logic [2:0]  ready3;
  logic [2:0]  gnt3;
  logic        winc3;
  logic        busy3;
  logic [7:0]  wdata3;

  logic [7:0] fq [$];
  int         fifoCount = 0;
  logic       clearFifo = 1'b0;
  logic       prefillFifo = 1'b0;
  logic       fifoRd = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Pack per-requester data into the flat bus.
  always_comb begin
    reqDataBus = '0;
    for (int k = 0; k < N; k++) reqDataBus[k*WIDTH +: WIDTH] = reqData[k];
  end

  assign wfull = (fifoCount >= 16);

  sfifo_wr_arb #(.WIDTH(WIDTH), .N(N), .MAX_BURST(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (reqValid),
    .i_req_last   (reqLast),
    .i_req_data   (reqDataBus),
    .o_req_ready  (reqReady),
    .i_fifo_wfull (wfull),
    .o_fifo_winc  (winc),
    .o_fifo_wdata (wdata),
    .o_gnt        (gnt),
    .o_busy       (busy)
  );

  sfifo_wr_arb #(.WIDTH(WIDTH), .N(3), .MAX_BURST(4)) dut3 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (vb3),
    .i_req_last   (last3),
    .i_req_data   (data3),
    .o_req_ready  (ready3),
    .i_fifo_wfull (1'b0),
    .o_fifo_winc  (winc3),
    .o_fifo_wdata (wdata3),
    .o_gnt        (gnt3),
    .o_busy       (busy3)
  );

  // FIFO model: clear/prefill requests, writes, then reads, all on the edge.
  always @(posedge clk) begin
    if (clearFifo) fq.delete();
    if (prefillFifo) for (int i = 0; i < 15; i++) fq.push_back(8'hE0 + 8'(i));
    if (winc) fq.push_back(wdata);
    if (fifoRd && fq.size() > 0) void'(fq.pop_front());
    fifoCount <= fq.size();
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l);
    reqValid = v;
    reqLast  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input bit clr, input bit pre);
    rst_n       = 1'b0;
    clearFifo   = clr;
    prefillFifo = pre;
    tick();
    clearFifo   = 1'b0;
    prefillFifo = 1'b0;
    rst_n       = 1'b1;
  endtask

  initial begin
    logic [3:0] expG;
    logic       expA;
    logic       prevAcc;
    int         w;

    reqValid = '0;
    reqLast  = '0;
    for (int k = 0; k < N; k++) reqData[k] = 8'hA0 + 8'(k);
    vb3   = '0;
    last3 = '0;
    data3 = 24'h332211;

    // Reset state
    rst_n = 1'b0;
    clearFifo = 1'b1;
    tick();
    clearFifo = 1'b0;
    tick();
    #1;
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", reqReady, 0);
    checkOutput("rst_winc", winc, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_gnt3", gnt3, 0);
    rst_n = 1'b1;

    // Single requester: 6 words, burst of 4, one IDLE cycle, then 2 more
    reqData[0] = 8'h10;
    applyStimulus(4'b0001, 4'b0000);
    #1;
    checkOutput("t1_idle_gnt", gnt, 0);
    w = 0;
    prevAcc = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      tick();
      if (prevAcc) begin
        w++;
        reqData[0] = 8'h10 + 8'(w);
        if (w == 6) reqValid[0] = 1'b0;
      end
      #1;
      expG = (c == 4 || c == 8) ? 4'b0000 : 4'b0001;
      expA = (c <= 3) || (c == 5) || (c == 6);
      checkOutput("t1_gnt", gnt, expG);
      checkOutput("t1_busy", busy, (expG != 0));
      checkOutput("t1_winc", winc, expA);
      if (expA) checkOutput("t1_wdata", wdata, 8'h10 + 8'(w));
      prevAcc = expA;
    end
    checkOutput("t1_fifo_count", fq.size(), 6);
    for (int i = 0; i < 6; i++) checkOutput("t1_fifo_word", fq[i], 8'h10 + 8'(i));

    // Round-robin: every requester sends single-word packets
    doReset(1'b1, 1'b0);
    for (int k = 0; k < N; k++) reqData[k] = 8'h20 + 8'(k);
    applyStimulus(4'b1111, 4'b1111);
    for (int c = 0; c <= 8; c++) begin
      tick();
      #1;
      expG = (c % 2 == 0) ? 4'(1 << ((c / 2) % 4)) : 4'b0000;
      checkOutput("t2_gnt", gnt, expG);
      checkOutput("t2_ready", reqReady, expG);
      if (c % 2 == 0) checkOutput("t2_wdata", wdata, 8'h20 + 8'((c / 2) % 4));
    end
    applyStimulus(4'b0000, 4'b0000);

    // Full back-pressure: FIFO prefilled to 15, req2 sends 3 words
    doReset(1'b1, 1'b1);
    reqData[2] = 8'h30;
    applyStimulus(4'b0100, 4'b0000);
    tick(); #1;
    checkOutput("t3_c0_gnt", gnt, 4'b0100);
    checkOutput("t3_c0_winc", winc, 1);
    checkOutput("t3_c0_wdata", wdata, 8'h30);
    tick();
    reqData[2] = 8'h31;
    #1;
    checkOutput("t3_c1_winc", winc, 0);
    checkOutput("t3_c1_ready", reqReady, 0);
    checkOutput("t3_c1_gnt", gnt, 4'b0100);
    tick(); #1;
    checkOutput("t3_c2_winc", winc, 0);
    checkOutput("t3_c2_gnt", gnt, 4'b0100);
    fifoRd = 1'b1;
    tick();
    fifoRd = 1'b0;
    #1;
    checkOutput("t3_c3_winc", winc, 1);
    checkOutput("t3_c3_wdata", wdata, 8'h31);
    checkOutput("t3_c3_ready", reqReady, 4'b0100);
    tick();
    reqData[2] = 8'h32;
    #1;
    checkOutput("t3_c4_winc", winc, 0);
    fifoRd = 1'b1;
    tick();
    fifoRd = 1'b0;
    #1;
    checkOutput("t3_c5_winc", winc, 1);
    checkOutput("t3_c5_wdata", wdata, 8'h32);
    tick();
    applyStimulus(4'b0000, 4'b0000);
    #1;
    checkOutput("t3_c6_gnt", gnt, 4'b0100);
    checkOutput("t3_c6_winc", winc, 0);
    tick(); #1;
    checkOutput("t3_c7_gnt", gnt, 0);
    checkOutput("t3_c7_busy", busy, 0);
    checkOutput("t3_fifo_count", fq.size(), 16);
    checkOutput("t3_fifo_13", fq[13], 8'h30);
    checkOutput("t3_fifo_14", fq[14], 8'h31);
    checkOutput("t3_fifo_15", fq[15], 8'h32);

    // Withdraw: req1 drops after 2 words, next arbitration starts at 2
    doReset(1'b1, 1'b0);
    reqData[1] = 8'h40;
    applyStimulus(4'b0010, 4'b0000);
    tick(); #1;
    checkOutput("t4_c0_gnt", gnt, 4'b0010);
    checkOutput("t4_c0_wdata", wdata, 8'h40);
    tick();
    reqData[1] = 8'h41;
    #1;
    checkOutput("t4_c1_wdata", wdata, 8'h41);
    checkOutput("t4_c1_winc", winc, 1);
    tick();
    reqData[0] = 8'h42;
    reqData[3] = 8'h43;
    applyStimulus(4'b1001, 4'b1000);
    #1;
    checkOutput("t4_c2_gnt", gnt, 4'b0010);
    checkOutput("t4_c2_winc", winc, 0);
    checkOutput("t4_c2_ready", reqReady, 0);
    tick(); #1;
    checkOutput("t4_c3_gnt", gnt, 0);
    tick(); #1;
    checkOutput("t4_c4_gnt", gnt, 4'b1000);
    checkOutput("t4_c4_wdata", wdata, 8'h43);
    tick();
    applyStimulus(4'b0001, 4'b0001);
    #1;
    checkOutput("t4_c5_gnt", gnt, 0);
    tick(); #1;
    checkOutput("t4_c6_gnt", gnt, 4'b0001);
    checkOutput("t4_c6_wdata", wdata, 8'h42);

    // Reset mid-burst: req2 is granted with ptr at 1, reset mid-burst
    tick();
    reqData[2] = 8'h60;
    applyStimulus(4'b0100, 4'b0000);
    #1;
    checkOutput("t6_idle_gnt", gnt, 0);
    tick(); #1;
    checkOutput("t6_d0_gnt", gnt, 4'b0100);
    checkOutput("t6_d0_wdata", wdata, 8'h60);
    tick();
    reqData[2] = 8'h61;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_d1_winc", winc, 1);
    tick(); #1;
    checkOutput("t6_rst_gnt", gnt, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_winc", winc, 0);
    checkOutput("t6_rst_ready", reqReady, 0);
    rst_n = 1'b1;
    reqData[0] = 8'h62;
    applyStimulus(4'b0101, 4'b0000);
    tick(); #1;
    checkOutput("t6_regrant", gnt, 4'b0001);
    checkOutput("t6_regrant_wdata", wdata, 8'h62);
    checkOutput("t6_fifo_count", fq.size(), 6);
    checkOutput("t6_fifo_5", fq[5], 8'h61);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    tick();

    // Wrap with N=3: ptr reaches 2, then wraps to 0
    vb3   = 3'b010;
    last3 = 3'b010;
    tick(); #1;
    checkOutput("t5_e0_gnt3", gnt3, 3'b010);
    tick();
    vb3   = 3'b101;
    last3 = 3'b101;
    #1;
    checkOutput("t5_e1_gnt3", gnt3, 3'b000);
    tick(); #1;
    checkOutput("t5_e2_gnt3", gnt3, 3'b100);
    checkOutput("t5_e2_winc3", winc3, 1);
    tick(); #1;
    checkOutput("t5_e3_gnt3", gnt3, 3'b000);
    tick(); #1;
    checkOutput("t5_e4_gnt3", gnt3, 3'b001);
    checkOutput("t5_e4_ready3", ready3, 3'b001);
    tick(); #1;
    checkOutput("t5_e5_gnt3", gnt3, 3'b000);
    tick(); #1;
    checkOutput("t5_e6_gnt3", gnt3, 3'b100);
    vb3 = 3'b000;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
